md_issue_ctrl: RTL and testbench

E-stage issue controller that sits directly upstream of the HI/LO multiply-divide unit (MD) in the pipelined MIPS core.
- Gates and drives the MD request signals (start, MDOp, A, B, mthi, mtlo, WD) from E-stage decode and forwarded operands.
- Tracks in-flight MD latency with a shadow counter.
- Produces the D-stage stall for any instruction that touches HI/LO while MD work is pending.
- Cancels pending work on interrupt/exception.

---
 rtl/md_pkg.sv | 21 ++
 rtl/md_shadow_cnt.sv | 32 +++
 rtl/md_issue_ctrl.sv | 111 +++++++++++
 tb/tb_md_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared MD definitions: MDOp codes, issue FSM states, default latencies.
// MD_CHECK_EN enables the md_err consistency checker in md_issue_ctrl.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 9;
  localparam int CNT_W_DEF   = 4;

endpackage

// File: rtl/md_shadow_cnt.sv
// Shadow latency counter: clear beats load beats decrement.
// o_pending is high while the count is nonzero.
module md_shadow_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_pending
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_pending = (r_cnt != '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the HI/LO multiply-divide unit.
// Define MD_CHECK_EN to add the sticky md_err consistency output.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_md_use,
  input  logic        e_valid,
  input  logic        e_md_start,
  input  logic [1:0]  e_md_op,
  input  logic        e_mthi,
  input  logic        e_mtlo,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        intreq,
  input  logic        md_busy,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [31:0] md_wd,
  output logic        md_mthi,
  output logic        md_mtlo,
  output logic        md_stall,
`ifdef MD_CHECK_EN
  output logic        md_err,
`endif
  output logic        md_pending
);

  logic             w_req_ok;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_load_val;
  md_state_e        r_state;
  md_state_e        w_state_nxt;

  // Interrupts and in-flight work both squash any E-stage request
  assign w_req_ok = e_valid & ~intreq & ~md_pending & ~reset;

  assign md_start = w_req_ok & e_md_start;
  assign md_mthi  = w_req_ok & e_mthi;
  assign md_mtlo  = w_req_ok & e_mtlo;
  assign md_op    = reset ? 2'b00 : e_md_op;
  assign md_a     = e_rs;
  assign md_b     = e_rt;
  assign md_wd    = e_rs;

  assign md_stall = d_md_use & (md_start | md_busy | md_pending);

  assign w_load_val = e_md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

  md_shadow_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (intreq),
    .i_load     (md_start),
    .i_load_val (w_load_val),
    .o_cnt      (w_cnt),
    .o_pending  (md_pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (md_start) w_state_nxt = S_RUN;
      S_RUN:  if (w_cnt == CNT_W'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (intreq) w_state_nxt = S_IDLE;
  end

`ifdef MD_CHECK_EN
  logic r_err;
  logic r_intreq_d;
  logic w_viol;
  logic w_mis;

  assign w_viol = e_valid & (e_md_start | e_mthi | e_mtlo) & md_pending;
  assign w_mis  = (md_pending != md_busy) & ~r_intreq_d;
  assign md_err = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err      <= 1'b0;
      r_intreq_d <= 1'b0;
    end else begin
      r_intreq_d <= intreq;
      if (w_viol | w_mis) begin
        r_err <= 1'b1;
`ifndef SYNTHESIS
        if (!r_err)
          $display("md_err t=%0t cnt=%0d busy=%0b", $time, w_cnt, md_busy);
`endif
      end
    end
  end
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small MD busy model.
// Build with MD_CHECK_EN to also exercise md_err.
module tb_md_issue_ctrl;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        d_md_use = 1'b0;
  logic        e_valid = 1'b0;
  logic        e_md_start = 1'b0;
  logic [1:0]  e_md_op = 2'b00;
  logic        e_mthi = 1'b0;
  logic        e_mtlo = 1'b0;
  logic [31:0] e_rs = '0;
  logic [31:0] e_rt = '0;
  logic        intreq = 1'b0;
  logic        md_busy;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_wd;
  logic        md_mthi;
  logic        md_mtlo;
  logic        md_stall;
  logic        md_pending;
`ifdef MD_CHECK_EN
  logic        md_err;
`endif

  int n_chk = 0;
  int n_err = 0;
  int bcnt;
  int stalls;
  int pend;
  int mism;

  md_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_md_use   (d_md_use),
    .e_valid    (e_valid),
    .e_md_start (e_md_start),
    .e_md_op    (e_md_op),
    .e_mthi     (e_mthi),
    .e_mtlo     (e_mtlo),
    .e_rs       (e_rs),
    .e_rt       (e_rt),
    .intreq     (intreq),
    .md_busy    (md_busy),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_a       (md_a),
    .md_b       (md_b),
    .md_wd      (md_wd),
    .md_mthi    (md_mthi),
    .md_mtlo    (md_mtlo),
    .md_stall   (md_stall),
`ifdef MD_CHECK_EN
    .md_err     (md_err),
`endif
    .md_pending (md_pending)
  );

  always #5 clk = ~clk;

  // Stand-in MD: busy for 4 (mul) or 9 (div) cycles after start
  always @(posedge clk or posedge reset) begin
    if (reset)         bcnt <= 0;
    else if (intreq)   bcnt <= 0;
    else if (md_start) bcnt <= md_op[1] ? 9 : 4;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign md_busy = (bcnt != 0);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bubble();
    e_valid = 1'b0;
    e_md_start = 1'b0;
    e_mthi = 1'b0;
    e_mtlo = 1'b0;
    intreq = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bubble();
    e_valid = 1'b1;
    e_md_start = 1'b1;
    e_md_op = op;
    e_rs = a;
    e_rt = b;
  endtask

  task automatic drain(input int n, input logic use_d);
    stalls = 1;
    pend = 0;
    mism = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bubble();
      d_md_use = use_d;
      #1;
      if (md_stall) stalls++;
      if (md_pending) pend++;
      if (md_pending != md_busy) mism++;
      if (md_start) mism++;
    end
  endtask

  initial begin
    #12;
    chk("rst_pend", md_pending, 0);
    chk("rst_start", md_start, 0);
`ifdef MD_CHECK_EN
    chk("rst_err", md_err, 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // MULT 7 * -3, mflo waiting in D
    @(negedge clk);
    issue(MD_MULT, 32'd7, 32'hFFFF_FFFD);
    d_md_use = 1'b1;
    #1;
    chk("mul_start", md_start, 1);
    chk("mul_op", md_op, 2'b01);
    chk("mul_a", md_a, 32'd7);
    chk("mul_b", md_b, 32'hFFFF_FFFD);
    chk("mul_stall0", md_stall, 1);
    drain(8, 1'b1);
    chk("mul_pend", pend, 4);
    chk("mul_stalls", stalls, 5);
    chk("mul_lock", mism, 0);

    // DIVU 100 / 7, mfhi waiting in D
    @(negedge clk);
    issue(MD_DIVU, 32'd100, 32'd7);
    d_md_use = 1'b1;
    #1;
    chk("divu_start", md_start, 1);
    chk("divu_op", md_op, 2'b10);
    drain(12, 1'b1);
    chk("divu_pend", pend, 9);
    chk("divu_stalls", stalls, 10);
    chk("divu_lock", mism, 0);

    // DIV cancelled by intreq two cycles after start
    @(negedge clk);
    issue(MD_DIV, 32'd50, 32'd5);
    d_md_use = 1'b1;
    @(negedge clk);
    bubble();
    @(negedge clk);
    intreq = 1'b1;
    #1;
    chk("irq_pend_hold", md_pending, 1);
    chk("irq_stall_hold", md_stall, 1);
    @(negedge clk);
    bubble();
    #1;
    chk("irq_pend_clr", md_pending, 0);
    chk("irq_stall_clr", md_stall, 0);

    // intreq alongside a MULT in E
    @(negedge clk);
    issue(MD_MULT, 32'd3, 32'd4);
    intreq = 1'b1;
    d_md_use = 1'b0;
    #1;
    chk("irq_mul_start", md_start, 0);
    @(negedge clk);
    bubble();
    d_md_use = 1'b1;
    #1;
    chk("irq_mul_pend", md_pending, 0);
    chk("irq_mul_stall", md_stall, 0);

    // mthi / mtlo while idle, mf in D not stalled
    @(negedge clk);
    bubble();
    e_valid = 1'b1;
    e_mthi = 1'b1;
    e_rs = 32'h1234;
    d_md_use = 1'b1;
    #1;
    chk("mthi", md_mthi, 1);
    chk("mthi_mtlo", md_mtlo, 0);
    chk("mthi_wd", md_wd, 32'h1234);
    chk("mthi_stall", md_stall, 0);
    @(negedge clk);
    bubble();
    e_valid = 1'b1;
    e_mtlo = 1'b1;
    e_rs = 32'h55;
    #1;
    chk("mtlo", md_mtlo, 1);
    chk("mtlo_mthi", md_mthi, 0);
    chk("mtlo_wd", md_wd, 32'h55);

    // Requests in E while pending are dropped
    @(negedge clk);
    issue(MD_MULT, 32'd1, 32'd2);
    d_md_use = 1'b0;
    @(negedge clk);
    issue(MD_DIV, 32'd9, 32'd3);
    e_mthi = 1'b1;
    #1;
    chk("viol_start", md_start, 0);
    chk("viol_mthi", md_mthi, 0);
    drain(6, 1'b0);
    chk("viol_pend", pend, 3);
`ifdef MD_CHECK_EN
    chk("viol_err", md_err, 1);
`endif

    // Reset mid-DIV at cnt=5
    @(negedge clk);
    issue(MD_DIV, 32'd90, 32'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bubble();
    end
    #1;
    chk("rst_mid_pend0", md_pending, 1);
    reset = 1'b1;
    issue(MD_MULT, 32'd4, 32'd4);
    #1;
    chk("rst_mid_pend", md_pending, 0);
    chk("rst_mid_start", md_start, 0);
    chk("rst_mid_mthi", md_mthi, 0);
    @(negedge clk);
    reset = 1'b0;
    bubble();
    #1;
    chk("post_rst_pend", md_pending, 0);
    chk("post_rst_start", md_start, 0);
`ifdef MD_CHECK_EN
    chk("post_rst_err", md_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
